// File: rtl/adder_arb_pkg.sv
// Shared constants, result record and index helper for the round-robin adder.
package adder_arb_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefIdW       = $clog2(DefNumReq);

  // Result slot contents at the default sizing: sum carries the carry-out in its MSB.
  typedef struct packed {
    logic [DefDataWidth:0] sum;
    logic [DefIdW-1:0]     id;
  } result_t;

  // Circular increment modulo n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, scanning circularly.
module adder_rr_arbiter_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  // Circular priority scan; the grant is suppressed when en_i is low but idx_o still resolves.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = ptr_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
      cand = ID_W'(next_idx(32'(cand), NUM_REQ));
    end
    if (en_i && found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin shared adder: one job accepted per cycle into a one-entry tagged result slot.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ID_W       = $clog2(NUM_REQ),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH:0]           out_sum,
  output logic [ID_W-1:0]               out_id,
  output logic [CNT_W-1:0]              acc_cnt
);

  logic                  slot_free;
  logic                  accept;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0]   out_sum_q, out_sum_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;

  // The slot can take a new result if it is empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Gating with resetn keeps every ready low while reset is held.
  adder_rr_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (slot_free && resetn),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  // A grant is only ever issued to a valid requester, so any grant is an accept.
  assign accept    = |(req_valid & gnt);

  assign op_a = req_a[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign op_b = req_b[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

  // Next-state: load on accept (also covers simultaneous drain), clear valid on a pure drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    acc_cnt_d   = acc_cnt_q;
    if (accept) begin
      out_sum_d   = {1'b0, op_a} + {1'b0, op_b};
      out_id_d    = gnt_idx;
      out_valid_d = 1'b1;
      rr_ptr_d    = ID_W'(next_idx(32'(gnt_idx), NUM_REQ));
      acc_cnt_d   = acc_cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Slot, pointer and counter registers; reset discards any pending result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      acc_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;
  assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter.
module tb_adder_rr_arbiter;
  import adder_arb_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW:0]      out_sum;
  logic [IW-1:0]    out_id;
  logic [CW-1:0]    acc_cnt;

  int errors = 0;
  int checks = 0;

  adder_rr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_W       (IW),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id),
    .acc_cnt   (acc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Requester hold rule: a valid not yet accepted must stay valid with stable operands.
  logic [NR-1:0]    pv = '0;
  logic [NR-1:0]    pr = '0;
  logic [NR*DW-1:0] pa = '0;
  logic [NR*DW-1:0] pb = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      pv <= '0;
    end else begin
      pv <= req_valid;
      pr <= req_ready;
      pa <= req_a;
      pb <= req_b;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < NR; i++) begin
        if (pv[i] && !pr[i]) begin
          checks++;
          if (!req_valid[i] || req_a[i*DW +: DW] !== pa[i*DW +: DW] ||
              req_b[i*DW +: DW] !== pb[i*DW +: DW]) begin
            errors++;
            $display("FAIL hold_rule req%0d: valid=%b a=%h b=%h required a=%h b=%h", i,
                     req_valid[i], req_a[i*DW +: DW], req_b[i*DW +: DW],
                     pa[i*DW +: DW], pb[i*DW +: DW]);
          end
        end
      end
    end
  end

  // Default operands: sum for requester i is 8'h11*(i+1).
  task automatic set_ops();
    req_a = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b = {8'h04, 8'h03, 8'h02, 8'h01};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_ops();
    req_valid = 4'hF;
    out_ready = 1'b1;
    resetn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h want 0000", acc_cnt); end
    checks++; if (out_sum !== 9'h000) begin errors++; $display("FAIL reset_sum: got %h want 000", out_sum); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", out_id); end
    resetn = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready: got %b want 0001", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_grant_valid: got %b want 1", out_valid); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL first_grant_id: got %0d want 0", out_id); end
    checks++; if (out_sum !== 9'h011) begin errors++; $display("FAIL first_grant_sum: got %h want 011", out_sum); end
    checks++; if (acc_cnt !== 16'h0001) begin errors++; $display("FAIL first_grant_cnt: got %h want 0001", acc_cnt); end
  endtask

  task automatic test_single_add();
    do_reset();
    set_ops();
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h01;
    req_valid    = 4'b0100;
    out_ready    = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 9'h100) begin errors++; $display("FAIL single_sum: got %h want 100", out_sum); end
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", out_id); end
    checks++; if (acc_cnt !== 16'h0001) begin errors++; $display("FAIL single_cnt: got %h want 0001", acc_cnt); end
    // Back-to-back all-ones job from requester 0 while the previous result drains.
    req_valid   = 4'b0001;
    req_a[7:0]  = 8'hFF;
    req_b[7:0]  = 8'hFF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ones_ready: got %b want 0001", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid: got %b want 1", out_valid); end
    checks++; if (out_sum !== 9'h1FE) begin errors++; $display("FAIL ones_sum: got %h want 1fe", out_sum); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL ones_id: got %0d want 0", out_id); end
    checks++; if (acc_cnt !== 16'h0002) begin errors++; $display("FAIL ones_cnt: got %h want 0002", acc_cnt); end
    req_valid = '0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 9'h1FE) begin errors++; $display("FAIL drain_sum_hold: got %h want 1fe", out_sum); end
    checks++; if (acc_cnt !== 16'h0002) begin errors++; $display("FAIL drain_cnt: got %h want 0002", acc_cnt); end
  endtask

  task automatic test_round_robin();
    result_t exp_r [4];
    exp_r[0] = '{sum: 9'h011, id: 2'd0};
    exp_r[1] = '{sum: 9'h022, id: 2'd1};
    exp_r[2] = '{sum: 9'h033, id: 2'd2};
    exp_r[3] = '{sum: 9'h044, id: 2'd3};
    do_reset();
    set_ops();
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_id !== exp_r[k % 4].id) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, out_id, exp_r[k % 4].id); end
      checks++; if (out_sum !== exp_r[k % 4].sum) begin errors++; $display("FAIL rr_sum[%0d]: got %h want %h", k, out_sum, exp_r[k % 4].sum); end
      checks++; if (acc_cnt !== 16'(k + 1)) begin errors++; $display("FAIL rr_cnt[%0d]: got %0d want %0d", k, acc_cnt, k + 1); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ops();
    req_valid = 4'b0010;
    out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready: got %b want 0010", req_ready); end
    step();
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL bp_first_id: got %0d want 1", out_id); end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum !== 9'h022 || acc_cnt !== 16'h0001) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%0d sum=%h cnt=%h want 1/1/022/0001", k, out_valid, out_id, out_sum, acc_cnt);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", out_valid); end
    checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL bp_release_id: got %0d want 2", out_id); end
    checks++; if (out_sum !== 9'h033) begin errors++; $display("FAIL bp_release_sum: got %h want 033", out_sum); end
    checks++; if (acc_cnt !== 16'h0002) begin errors++; $display("FAIL bp_release_cnt: got %h want 0002", acc_cnt); end
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_ops();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    step();
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL skip_pre_id: got %0d want 0", out_id); end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_ready0: got %b want 1000", req_ready); end
    step();
    checks++; if (out_id !== 2'd3 || out_sum !== 9'h044) begin errors++; $display("FAIL skip_res0: got id=%0d sum=%h want 3/044", out_id, out_sum); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_ready1: got %b want 0001", req_ready); end
    step();
    checks++; if (out_id !== 2'd0 || out_sum !== 9'h011) begin errors++; $display("FAIL skip_res1: got id=%0d sum=%h want 0/011", out_id, out_sum); end
    checks++; if (acc_cnt !== 16'h0003) begin errors++; $display("FAIL skip_cnt: got %h want 0003", acc_cnt); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_ready2: got %b want 1000", req_ready); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    set_ops();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (acc_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffff", acc_cnt); end
    step();
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", acc_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    out_ready = 1'b0;
    req_valid = '0;
    step();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_bp_ready: got %b want 0000", req_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_bp_valid: got %b want 1", out_valid); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 9'h000 || out_id !== 2'd0) begin errors++; $display("FAIL async_slot: got sum=%h id=%0d want 000/0", out_sum, out_id); end
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL async_cnt: got %h want 0000", acc_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL async_ready: got %b want 0000", req_ready); end
    #2 resetn = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready: got %b want 0001", req_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || acc_cnt !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset_accept: got valid=%b id=%0d cnt=%h want 1/0/0001", out_valid, out_id, acc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares a single combinational ripple-carry adder between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes on both sides. One operation is accepted per cycle. The sum, including carry-out, is registered into a one-entry output slot tagged with the requester index. It sits between the client blocks that issue add jobs and the downstream consumer of results.

Parameters:
DATA_WIDTH, 8, operand width in bits.
NUM_REQ, 4, number of requesters (>=2).
ID_W, $clog2(NUM_REQ), requester-index width.
CNT_W, 16, width of the accepted-operation counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester job valid.
req_ready  out  NUM_REQ  per-requester accept (at most one bit high).
req_a  in  NUM_REQ*DATA_WIDTH  packed operand A; slice i = requester i.
req_b  in  NUM_REQ*DATA_WIDTH  packed operand B; slice i = requester i.
out_valid  out  1  result slot holds a valid result.
out_ready  in  1  consumer accepts the result.
out_sum  out  DATA_WIDTH+1  a+b; MSB = carry-out.
out_id  out  ID_W  index of the requester that produced out_sum.
acc_cnt  out  CNT_W  count of accepted jobs, wraps.

Behaviour:
- Reset (resetn=0, async): out_valid=0, out_sum=0, out_id=0, acc_cnt=0, rr_ptr=0. req_ready is forced to all-0 while resetn=0.
- slot_free = !out_valid || out_ready (combinational).
- Grant g = first i with req_valid[i]=1, scanning circularly from rr_ptr (rr_ptr, rr_ptr+1, ..., wrap to 0).
- req_ready[g] = slot_free. All other req_ready bits = 0. req_ready is combinational from req_valid, out_valid, out_ready and rr_ptr. No ready-before-valid.
- Accept = req_valid[g] && req_ready[g]. On accept:
  - out_sum <= zero-extended a[g] + b[g] (DATA_WIDTH+1 bits, no truncation).
  - out_id <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - acc_cnt <= acc_cnt+1 (wraps 2^CNT_W-1 -> 0).
- No accept, and out_valid && out_ready: out_valid <= 0. out_sum and out_id hold their last values.
- No accept, and slot not drained: all state holds. rr_ptr does not move when no grant is made.
- Simultaneous drain and accept: the old result is consumed and the new result is loaded in the same edge, so out_valid stays 1. Sustained throughput is 1 job/cycle.
- Latency: accept at edge N -> out_valid=1 with the result after edge N (1 cycle).
- Backpressure: out_valid=1 and out_ready=0 -> every req_ready=0. out_sum and out_id are stable until consumed.
- Requester rule: once req_valid[i] is high it must stay high, with stable operands, until req_ready[i]. Violation is checked by assertion in the bench, not handled by the RTL.
- Single requester active: it is granted every cycle the slot is free, regardless of rr_ptr.
- Reset mid-operation: a pending result is discarded and nothing is replayed. Requesters re-present their jobs after reset.
- Arithmetic edge case: all-ones + all-ones = {1'b1, all-ones<<1}. Carry lands only in out_sum[DATA_WIDTH].

Decomposition:
- Shared package adder_arb_pkg holds:
  - default DATA_WIDTH and NUM_REQ constants;
  - typedef for the result record {sum, id};
  - function next_idx(idx, n) for circular increment.
- One sub-module is natural: rr_arbiter (NUM_REQ). Inputs: req vector, rr_ptr, enable. Outputs: one-hot grant and encoded index. It is purely combinational.
- The adder itself is an inline expression.
- Top level owns the slot register, rr_ptr and acc_cnt.

Test Plan:
1. Reset then idle: resetn low for 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, acc_cnt=0. First edge after release grants requester 0.
2. Single add: req 2 presents a=8'hFF, b=8'h01, out_ready=1 -> accepted in 1 cycle. Next cycle out_valid=1, out_sum=9'h100, out_id=2, acc_cnt=1.
3. Round-robin fairness: all 4 valid continuously, out_ready=1 -> grant order 0,1,2,3,0,... with one result per cycle and no gaps.
4. Backpressure: hold out_ready=0 with a result pending for 5 cycles -> all req_ready=0, out_sum/out_id stable. Releasing out_ready gives drain and new accept on the same edge.
5. Pointer skip: rr_ptr=1, only req 0 and req 3 valid -> req 3 is granted first, then req 0. rr_ptr becomes 0, then 1.
6. Wrap and reset: preload acc_cnt to 16'hFFFF via 65535 accepts, then accept one more -> acc_cnt=0. Asserting resetn mid-backpressure clears out_valid asynchronously.
